// File: rtl/fp_core_arbiter.sv
// Two-client round-robin front end that feeds the 16-bit serial FP core and returns its results.
// Latency: req_ready one cycle after the request is seen in IDLE, first core_ri one cycle later, beats registered.
// Backpressure: none on responses; requests wait in IDLE and are never accepted while a job is in flight.
module fp_core_arbiter #(
    parameter int DONE_GAP = 64,
    parameter int MAX_WAIT = 256,
    parameter int RST_CYC  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic [1:0]  req_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic        rsp_tmo,
    output logic        rsp_last,
    output logic [15:0] core_din,
    output logic        core_ri,
    output logic        core_rst,
    input  logic        core_ro,
    input  logic [1:0]  core_err,
    input  logic [31:0] core_dout
);

    localparam int CMAX     = (MAX_WAIT > DONE_GAP) ? MAX_WAIT : DONE_GAP;
    localparam int CW       = $clog2(CMAX) + 1;
    localparam int COOL_CYC = 2;

    localparam logic [CW-1:0] GAP_LAST  = CW'(DONE_GAP - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOL_CYC - 1);

    typedef enum logic [3:0] {
        S_COOL,
        S_IDLE,
        S_SEND0,
        S_SEND1,
        S_SEND2,
        S_SEND3,
        S_WAIT,
        S_RSTC,
        S_LERR
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last_id, last_id_nxt;   // client granted most recently
    logic          job_id, job_id_nxt;
    logic [31:0]   op_a, op_a_nxt;
    logic [31:0]   op_b, op_b_nxt;
    logic          seen, seen_nxt;         // at least one result in this job
    logic [31:0]   last_res, last_res_nxt;
    logic          ro_q;

    logic [1:0]    req_ready_nxt;
    logic          rsp_valid_nxt;
    logic          rsp_id_nxt;
    logic [31:0]   rsp_data_nxt;
    logic [1:0]    rsp_err_nxt;
    logic          rsp_tmo_nxt;
    logic          rsp_last_nxt;
    logic [15:0]   core_din_nxt;
    logic          core_ri_nxt;
    logic          core_rst_nxt;

    logic          grant_id;
    logic [31:0]   a_sel;
    logic [31:0]   b_sel;
    logic          ro_rise;

    // Next-state, next-output and job-context computation; all outputs are registered from these.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_id_nxt   = last_id;
        job_id_nxt    = job_id;
        op_a_nxt      = op_a;
        op_b_nxt      = op_b;
        seen_nxt      = seen;
        last_res_nxt  = last_res;
        req_ready_nxt = 2'b00;
        rsp_valid_nxt = 1'b0;
        rsp_id_nxt    = 1'b0;
        rsp_data_nxt  = 32'd0;
        rsp_err_nxt   = 2'b00;
        rsp_tmo_nxt   = 1'b0;
        rsp_last_nxt  = 1'b0;
        core_din_nxt  = 16'd0;
        core_ri_nxt   = 1'b0;
        core_rst_nxt  = 1'b0;

        // With both requesting, the one not served last wins; a lone requester always wins.
        grant_id = (&req_valid) ? ~last_id : req_valid[1];
        a_sel    = grant_id ? req_a1 : req_a0;
        b_sel    = grant_id ? req_b1 : req_b0;
        ro_rise  = core_ro & ~ro_q;

        case (state)
            S_COOL: begin
                // Give the core time to settle into its first-word wait state.
                if (cnt == COOL_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_IDLE: begin
                if (|req_valid) begin
                    req_ready_nxt = grant_id ? 2'b10 : 2'b01;
                    job_id_nxt    = grant_id;
                    last_id_nxt   = grant_id;
                    op_a_nxt      = a_sel;
                    op_b_nxt      = b_sel;
                    // +/-0 as A is rejected locally; the core is never disturbed.
                    state_nxt     = (a_sel[30:0] == 31'd0) ? S_LERR : S_SEND0;
                end
            end
            S_SEND0: begin
                core_ri_nxt  = 1'b1;
                core_din_nxt = op_a[31:16];
                state_nxt    = S_SEND1;
            end
            S_SEND1: begin
                core_ri_nxt  = 1'b1;
                core_din_nxt = op_a[15:0];
                state_nxt    = S_SEND2;
            end
            S_SEND2: begin
                core_ri_nxt  = 1'b1;
                core_din_nxt = op_b[31:16];
                state_nxt    = S_SEND3;
            end
            S_SEND3: begin
                core_ri_nxt  = 1'b1;
                core_din_nxt = op_b[15:0];
                state_nxt    = S_WAIT;
                cnt_nxt      = '0;
                seen_nxt     = 1'b0;
            end
            S_WAIT: begin
                rsp_id_nxt = job_id;
                if (core_err != 2'b00) begin
                    // An error outranks a result edge arriving in the same cycle.
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = core_err;
                    rsp_last_nxt  = 1'b1;
                    state_nxt     = S_COOL;
                    cnt_nxt       = '0;
                end else if (ro_rise) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = core_dout;
                    last_res_nxt  = core_dout;
                    seen_nxt      = 1'b1;
                    cnt_nxt       = '0;
                end else if (seen && cnt == GAP_LAST) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = last_res;
                    rsp_last_nxt  = 1'b1;
                    state_nxt     = S_COOL;
                    cnt_nxt       = '0;
                end else if (!seen && cnt == WAIT_LAST) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_tmo_nxt   = 1'b1;
                    rsp_last_nxt  = 1'b1;
                    core_rst_nxt  = 1'b1;
                    state_nxt     = S_RSTC;
                    cnt_nxt       = '0;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RSTC: begin
                // core_rst went high on entry; keep it for the rest of the window.
                if (cnt == RST_LAST) begin
                    state_nxt = S_COOL;
                    cnt_nxt   = '0;
                end else begin
                    core_rst_nxt = 1'b1;
                    cnt_nxt      = cnt + CW'(1);
                end
            end
            S_LERR: begin
                rsp_valid_nxt = 1'b1;
                rsp_id_nxt    = job_id;
                rsp_err_nxt   = 2'b11;
                rsp_last_nxt  = 1'b1;
                state_nxt     = S_IDLE;
            end
            default: begin
                state_nxt = S_COOL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, job context and registered outputs; reset drops any job without a beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_COOL;
            cnt       <= '0;
            last_id   <= 1'b1;
            job_id    <= 1'b0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            seen      <= 1'b0;
            last_res  <= 32'd0;
            ro_q      <= 1'b0;
            req_ready <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= 2'b00;
            rsp_tmo   <= 1'b0;
            rsp_last  <= 1'b0;
            core_din  <= 16'd0;
            core_ri   <= 1'b0;
            core_rst  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last_id   <= last_id_nxt;
            job_id    <= job_id_nxt;
            op_a      <= op_a_nxt;
            op_b      <= op_b_nxt;
            seen      <= seen_nxt;
            last_res  <= last_res_nxt;
            ro_q      <= core_ro;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_id    <= rsp_id_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_tmo   <= rsp_tmo_nxt;
            rsp_last  <= rsp_last_nxt;
            core_din  <= core_din_nxt;
            core_ri   <= core_ri_nxt;
            core_rst  <= core_rst_nxt;
        end
    end

endmodule

// File: tb/tb_fp_core_arbiter.sv
// Scoreboard bench for fp_core_arbiter with a behavioural model of the serial FP core.
// Expectations are queued when stimulus is issued; monitors pop and compare on negedges.
// Directed jobs: normal, round-robin, zero-A reject, core error, timeout, reset mid-send.
module tb_fp_core_arbiter;

    localparam int DONE_GAP = 64;
    localparam int MAX_WAIT = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_ready;
    logic        rsp_valid, rsp_id, rsp_tmo, rsp_last;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic [15:0] core_din;
    logic        core_ri, core_rst;
    logic        core_ro;
    logic [1:0]  core_err;
    logic [31:0] core_dout;

    always #5 clk = ~clk;

    fp_core_arbiter #(.DONE_GAP(DONE_GAP), .MAX_WAIT(MAX_WAIT), .RST_CYC(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo), .rsp_last(rsp_last),
        .core_din(core_din), .core_ri(core_ri), .core_rst(core_rst),
        .core_ro(core_ro), .core_err(core_err), .core_dout(core_dout)
    );

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [1:0]  err;
        logic        tmo;
        logic        last;
        int          gap;    // >0: cycles since previous beat
        int          gmax;   // >0: at most this many cycles after the grant
        int          wgap;   // >0: cycles since the fourth operand word
    } beat_t;
    typedef struct {
        logic id;
        int   after_beat;    // >0: cycles since previous beat
    } grant_t;
    typedef struct {
        int          mode;   // 0 results, 1 error, 2 silent, 3 error with result edge
        int          n;
        logic [31:0] r0;
        logic [31:0] r1;
    } job_t;

    beat_t       exp_beats[$];
    grant_t      exp_grants[$];
    logic [15:0] exp_words[$];
    job_t        jobs[$];
    int          exp_rst[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    int post0 = 0, post1 = 0, acc0 = 0, acc1 = 0;
    int n_grants = 0, last_grant_cyc = 0, last_beat_cyc = 0, last_word4_cyc = 0;
    bit rst_chk_en = 1'b0;

    // A client keeps requesting until its accept pulse has been seen.
    assign req_valid = {post1 != acc1, post0 != acc0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_beat(input logic id, input logic [31:0] data, input logic [1:0] err,
                             input logic tmo, input logic last, input int gap, input int gmax,
                             input int wgap);
        beat_t b;
        b.id = id; b.data = data; b.err = err; b.tmo = tmo; b.last = last;
        b.gap = gap; b.gmax = gmax; b.wgap = wgap;
        exp_beats.push_back(b);
    endtask

    task automatic expect_job(input int id, input logic [31:0] a, input logic [31:0] b,
                              input int mode, input int n, input logic [31:0] r0,
                              input logic [31:0] r1, input int after_beat);
        grant_t g;
        job_t   j;
        g.id = id[0];
        g.after_beat = after_beat;
        exp_grants.push_back(g);
        if (a[30:0] == 31'd0) begin
            push_beat(id[0], 32'd0, 2'b11, 1'b0, 1'b1, 0, 2, 0);
            return;
        end
        exp_words.push_back(a[31:16]);
        exp_words.push_back(a[15:0]);
        exp_words.push_back(b[31:16]);
        exp_words.push_back(b[15:0]);
        j.mode = mode; j.n = n; j.r0 = r0; j.r1 = r1;
        jobs.push_back(j);
        case (mode)
            0: begin
                push_beat(id[0], r0, 2'b00, 1'b0, 1'b0, 0, 0, 0);
                if (n == 2) begin
                    push_beat(id[0], r1, 2'b00, 1'b0, 1'b0, 0, 0, 0);
                    push_beat(id[0], r1, 2'b00, 1'b0, 1'b1, DONE_GAP, 0, 0);
                end else begin
                    push_beat(id[0], r0, 2'b00, 1'b0, 1'b1, DONE_GAP, 0, 0);
                end
            end
            1, 3: push_beat(id[0], 32'd0, 2'b01, 1'b0, 1'b1, 0, 0, 0);
            default: push_beat(id[0], 32'd0, 2'b00, 1'b1, 1'b1, 0, 0, MAX_WAIT);
        endcase
    endtask

    task automatic post(input int id, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin req_a0 = a; req_b0 = b; post0++; end
        else begin req_a1 = a; req_b1 = b; post1++; end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k = 0;
        while ((exp_beats.size() + exp_grants.size() + exp_words.size() + jobs.size()) != 0 ||
               post0 != acc0 || post1 != acc1) begin
            @(negedge clk);
            k++;
            if (k >= limit) begin
                checks++;
                failures++;
                $display("FAIL %s: timeout, %0d beats %0d grants still expected",
                         name, exp_beats.size(), exp_grants.size());
                exp_beats.delete(); exp_grants.delete(); exp_words.delete(); jobs.delete();
                return;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_grants(input string name, input int n, input int limit);
        int k = 0;
        while (n_grants < n) begin
            @(negedge clk);
            k++;
            if (k >= limit) begin
                fail_now({name, " grant timeout"});
                return;
            end
        end
    endtask

    // Core model: collects operand words, then plays the scripted response.
    task automatic run_job(input job_t j);
        case (j.mode)
            0: begin
                repeat (3) @(negedge clk);
                for (int k = 0; k < j.n; k++) begin
                    core_dout = (k == 0) ? j.r0 : j.r1;
                    core_ro = 1'b1;
                    repeat (2) @(negedge clk);
                    core_ro = 1'b0;
                    repeat (3) @(negedge clk);
                end
            end
            1: begin
                @(negedge clk);
                core_err = 2'b01;
                @(negedge clk);
                core_err = 2'b00;
            end
            3: begin
                @(negedge clk);
                core_dout = 32'h1234_5678;
                core_ro = 1'b1;
                core_err = 2'b01;
                @(negedge clk);
                core_ro = 1'b0;
                core_err = 2'b00;
            end
            default: ;
        endcase
    endtask

    initial begin : core_model
        int   nwords;
        int   first_cyc;
        job_t j;
        nwords = 0;
        first_cyc = 0;
        core_ro = 1'b0; core_err = 2'b00; core_dout = 32'd0;
        forever begin
            @(negedge clk);
            if (core_rst === 1'b1) begin
                nwords = 0;
            end else if (core_ri === 1'b1) begin
                if (exp_words.size() == 0) fail_now("core_word_unexpected");
                else check("core_din", core_din, exp_words.pop_front());
                if (nwords == 0) first_cyc = cyc;
                nwords++;
                if (nwords == 4) begin
                    nwords = 0;
                    last_word4_cyc = cyc;
                    check("core_ri_burst", cyc - first_cyc, 3);
                    if (jobs.size() == 0) fail_now("core_job_unexpected");
                    else begin
                        j = jobs.pop_front();
                        run_job(j);
                    end
                end
            end
        end
    end

    initial begin : grant_mon
        grant_t g;
        forever begin
            @(negedge clk);
            if (|req_ready === 1'b1) begin
                n_grants++;
                last_grant_cyc = cyc;
                if (exp_grants.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_unexpected: got req_ready=%b (cycle %0d)", req_ready, cyc);
                end else begin
                    g = exp_grants.pop_front();
                    check("grant_id", req_ready, g.id ? 2'b10 : 2'b01);
                    if (g.after_beat > 0)
                        check("grant_after_cool", cyc - last_beat_cyc, g.after_beat);
                end
                if (req_ready[0]) acc0 = post0;
                if (req_ready[1]) acc1 = post1;
            end
        end
    end

    initial begin : rsp_mon
        beat_t b;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_beats.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got id=%0d data=%h err=%0d tmo=%0d last=%0d",
                             rsp_id, rsp_data, rsp_err, rsp_tmo, rsp_last);
                end else begin
                    b = exp_beats.pop_front();
                    check("rsp_beat", {rsp_id, rsp_data, rsp_err, rsp_tmo, rsp_last},
                          {b.id, b.data, b.err, b.tmo, b.last});
                    if (b.gap > 0) check("rsp_quiet_gap", cyc - last_beat_cyc, b.gap);
                    if (b.gmax > 0) check("rsp_after_grant", (cyc - last_grant_cyc) <= b.gmax, 1);
                    if (b.wgap > 0) check("rsp_timeout_delay", cyc - last_word4_cyc, b.wgap);
                end
                last_beat_cyc = cyc;
            end
        end
    end

    initial begin : rst_mon
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (core_rst === 1'b1) begin
                run++;
            end else begin
                if (run > 0 && rst_chk_en) begin
                    if (exp_rst.size() == 0) fail_now("core_rst_unexpected");
                    else check("core_rst_len", run, exp_rst.pop_front());
                end
                run = 0;
            end
        end
    end

    initial begin : main
        grant_t g;
        int     k;
        reset = 1'b0;
        req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_core_rst", core_rst, 1);
        check("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, rsp_tmo,
                                rsp_last, core_din, core_ri}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("core_rst_released", core_rst, 0);

        // Basic job from client 0: two results, then the quiet-gap final beat.
        expect_job(0, 32'h4000_0000, 32'h4040_0000, 0, 2, 32'h40A0_0000, 32'h40C0_0000, 0);
        post(0, 32'h4000_0000, 32'h4040_0000);
        wait_drain("basic_job", 400);

        // Signed-zero A values are rejected without touching the core.
        expect_job(0, 32'h8000_0000, 32'h3F80_0000, 0, 0, 32'd0, 32'd0, 0);
        post(0, 32'h8000_0000, 32'h3F80_0000);
        wait_drain("neg_zero_a", 50);
        expect_job(1, 32'h0000_0000, 32'h4000_0000, 0, 0, 32'd0, 32'd0, 0);
        post(1, 32'h0000_0000, 32'h4000_0000);
        wait_drain("zero_a", 50);

        // Round robin: simultaneous requests, then both re-request -> 0,1,0,1.
        expect_job(0, 32'h3F80_0000, 32'h4000_0000, 0, 1, 32'h4040_0000, 32'd0, 0);
        expect_job(1, 32'h4080_0000, 32'h40A0_0000, 0, 1, 32'h4110_0000, 32'd0, 0);
        k = n_grants;
        post(0, 32'h3F80_0000, 32'h4000_0000);
        post(1, 32'h4080_0000, 32'h40A0_0000);
        wait_grants("rr_first", k + 1, 100);
        expect_job(0, 32'h40E0_0000, 32'h3F00_0000, 0, 1, 32'h3F60_0000, 32'd0, 0);
        post(0, 32'h40E0_0000, 32'h3F00_0000);
        wait_grants("rr_second", k + 2, 300);
        expect_job(1, 32'h4120_0000, 32'h4130_0000, 0, 1, 32'h41A8_0000, 32'd0, 0);
        post(1, 32'h4120_0000, 32'h4130_0000);
        wait_drain("round_robin", 800);

        // Core error: single error beat, next grant only after the cool-down.
        expect_job(0, 32'h4120_0000, 32'h4000_0000, 1, 0, 32'd0, 32'd0, 0);
        expect_job(1, 32'h4040_0000, 32'h4040_0000, 0, 1, 32'h4110_0000, 32'd0, 3);
        post(0, 32'h4120_0000, 32'h4000_0000);
        post(1, 32'h4040_0000, 32'h4040_0000);
        wait_drain("core_error", 400);

        // Error and result edge together: the error wins.
        expect_job(0, 32'h3FC0_0000, 32'h3FC0_0000, 3, 0, 32'd0, 32'd0, 0);
        post(0, 32'h3FC0_0000, 32'h3FC0_0000);
        wait_drain("err_priority", 100);

        // Silent core: timeout beat, two-cycle core reset, then a normal job.
        rst_chk_en = 1'b1;
        exp_rst.push_back(2);
        expect_job(0, 32'h3F80_0000, 32'h3F80_0000, 2, 0, 32'd0, 32'd0, 0);
        k = n_grants;
        post(0, 32'h3F80_0000, 32'h3F80_0000);
        wait_grants("timeout", k + 1, 50);
        expect_job(1, 32'h4000_0000, 32'h4080_0000, 0, 1, 32'h4100_0000, 32'd0, 0);
        post(1, 32'h4000_0000, 32'h4080_0000);
        wait_drain("timeout", 1000);
        check("core_rst_windows", exp_rst.size(), 0);
        rst_chk_en = 1'b0;

        // Reset during SEND2: job dropped silently, pointer back to client 0.
        g.id = 1'b0;
        g.after_beat = 0;
        exp_grants.push_back(g);
        exp_words.push_back(16'h4140);
        exp_words.push_back(16'h0000);
        post(1, 32'h4160_0000, 32'h3F80_0000);
        post(0, 32'h4140_0000, 32'h4000_0000);
        k = 0;
        while (req_ready[0] !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("reset_test_grant", req_ready, 2'b01);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid_job", {core_ri, core_rst, rsp_valid}, 3'b010);
        reset = 1'b1;
        expect_job(0, 32'h4150_0000, 32'h4000_0000, 0, 1, 32'h41D0_0000, 32'd0, 0);
        expect_job(1, 32'h4160_0000, 32'h3F80_0000, 0, 1, 32'h4160_0000, 32'd0, 0);
        post(0, 32'h4150_0000, 32'h4000_0000);
        wait_drain("after_reset", 600);

        check("scoreboard_empty",
              exp_beats.size() + exp_grants.size() + exp_words.size() + jobs.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
